// File: rtl/mcpu_memio_port.sv
// Debug I/O port for the MCPU core: captures memoutput into a small FIFO, streams each word
// out little-endian as bytes over valid/ready, and drives meminput from a host-loadable register.
module mcpu_memio_port #(
    parameter int unsigned DEPTH       = 8,
    parameter bit          ON_CHANGE   = 1'b1,
    parameter logic [31:0] MEMIN_RESET = 32'd5
) (
    input  logic                     clkrst_core_clk,
    input  logic                     clkrst_core_rst,
    input  logic [31:0]              memoutput,
    input  logic                     cap_en,
    output logic [31:0]              meminput,
    input  logic                     host_in_valid,
    input  logic [31:0]              host_in_data,
    output logic                     byte_valid,
    output logic [7:0]               byte_data,
    input  logic                     byte_ready,
    output logic                     overflow,
    output logic [15:0]              drop_count,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = PtrW + 1;

    typedef enum logic {StIdle, StSend} state_e;

    state_e            state_q, state_d;
    logic [31:0]       shreg_q, shreg_d;
    logic [1:0]        idx_q, idx_d;
    logic              bvalid_q, bvalid_d;
    logic [31:0]       last_q, last_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]   level_q, level_d;
    logic              overflow_q, overflow_d;
    logic [15:0]       drops_q, drops_d;
    logic [31:0]       meminput_q, meminput_d;

    logic [31:0]       mem_q [DEPTH];

    logic capture;
    logic push;
    logic pop;

    always_comb begin
        capture    = cap_en && (!ON_CHANGE || (memoutput != last_q));
        last_d     = capture ? memoutput : last_q;
        meminput_d = host_in_valid ? host_in_data : meminput_q;

        state_d  = state_q;
        shreg_d  = shreg_q;
        idx_d    = idx_q;
        bvalid_d = bvalid_q;
        pop      = 1'b0;

        case (state_q)
            StIdle: begin
                if (level_q != '0) begin
                    pop      = 1'b1;
                    shreg_d  = mem_q[rd_ptr_q];
                    idx_d    = 2'd0;
                    bvalid_d = 1'b1;
                    state_d  = StSend;
                end
            end
            StSend: begin
                if (bvalid_q && byte_ready) begin
                    if (idx_q != 2'd3) begin
                        idx_d = idx_q + 2'd1;
                    end else if (level_q != '0) begin
                        // Chain straight into the next word so the stream has no bubble.
                        pop     = 1'b1;
                        shreg_d = mem_q[rd_ptr_q];
                        idx_d   = 2'd0;
                    end else begin
                        bvalid_d = 1'b0;
                        state_d  = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // A full FIFO still accepts a word if the head leaves at the same edge.
        push = capture && ((level_q < LvlW'(DEPTH)) || pop);

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;

        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        overflow_d = overflow_q;
        drops_d    = drops_q;
        if (capture && !push) begin
            overflow_d = 1'b1;
            if (drops_q != 16'hFFFF) begin
                drops_d = drops_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clkrst_core_clk) begin
        if (clkrst_core_rst) begin
            state_q    <= StIdle;
            shreg_q    <= '0;
            idx_q      <= '0;
            bvalid_q   <= 1'b0;
            last_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drops_q    <= '0;
            meminput_q <= MEMIN_RESET;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            idx_q      <= idx_d;
            bvalid_q   <= bvalid_d;
            last_q     <= last_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            drops_q    <= drops_d;
            meminput_q <= meminput_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and level alone.
    always_ff @(posedge clkrst_core_clk) begin
        if (push && !clkrst_core_rst) begin
            mem_q[wr_ptr_q] <= memoutput;
        end
    end

    always_comb begin
        case (idx_q)
            2'd0:    byte_data = shreg_q[7:0];
            2'd1:    byte_data = shreg_q[15:8];
            2'd2:    byte_data = shreg_q[23:16];
            default: byte_data = shreg_q[31:24];
        endcase
    end

    assign byte_valid = bvalid_q;
    assign meminput   = meminput_q;
    assign overflow   = overflow_q;
    assign drop_count = drops_q;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_mcpu_memio_port.sv
// Directed bench for mcpu_memio_port: a vector table for reset, capture, host load and
// backpressure, plus hand sequences for overflow and reset in the middle of a word.
module tb_mcpu_memio_port;

    logic        clk;
    logic        rst;
    logic [31:0] memoutput;
    logic        cap_en;
    logic [31:0] meminput;
    logic        host_in_valid;
    logic [31:0] host_in_data;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        overflow;
    logic [15:0] drop_count;
    logic [3:0]  fifo_level;

    int n_cmp = 0;
    int n_bad = 0;

    mcpu_memio_port #(
        .DEPTH      (8),
        .ON_CHANGE  (1'b1),
        .MEMIN_RESET(32'd5)
    ) dut (
        .clkrst_core_clk(clk),
        .clkrst_core_rst(rst),
        .memoutput      (memoutput),
        .cap_en         (cap_en),
        .meminput       (meminput),
        .host_in_valid  (host_in_valid),
        .host_in_data   (host_in_data),
        .byte_valid     (byte_valid),
        .byte_data      (byte_data),
        .byte_ready     (byte_ready),
        .overflow       (overflow),
        .drop_count     (drop_count),
        .fifo_level     (fifo_level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic        cap;
        logic [31:0] mo;
        logic        hv;
        logic [31:0] hd;
        logic        rdy;
        logic        e_bv;
        logic [7:0]  e_bd;
        logic        chk_bd;
        logic [3:0]  e_lvl;
        logic [31:0] e_min;
    } vec_t;

    vec_t tbl [25];

    function automatic vec_t mk(logic r, logic c, logic [31:0] mo, logic hv, logic [31:0] hd,
                                logic rdy, logic bv, logic [7:0] bd, logic cbd,
                                logic [3:0] lvl, logic [31:0] mi);
        vec_t v;
        v.rst = r;  v.cap = c;   v.mo = mo;    v.hv = hv;       v.hd = hd;  v.rdy = rdy;
        v.e_bv = bv; v.e_bd = bd; v.chk_bd = cbd; v.e_lvl = lvl; v.e_min = mi;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    logic [7:0]  got [36];
    logic [31:0] word;
    int          n_got;
    int          cyc;
    logic [31:0] w4 [4];

    initial begin
        rst = 1'b1; cap_en = 1'b0; memoutput = '0; host_in_valid = 1'b0;
        host_in_data = '0; byte_ready = 1'b0;

        // rst cap  memoutput      hv  host_data      rdy  bv  byte  chk lvl meminput
        tbl[0]  = mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 8'h00, 1, 0, 32'h5);
        tbl[1]  = mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 8'h00, 1, 0, 32'h5);
        tbl[2]  = mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 8'h00, 1, 0, 32'h5);
        tbl[3]  = mk(0, 1, 32'h0,        0, 32'h0,        0, 0, 8'h00, 1, 0, 32'h5);
        tbl[4]  = mk(0, 1, 32'h0,        0, 32'h0,        1, 0, 8'h00, 1, 0, 32'h5);
        tbl[5]  = mk(0, 1, 32'h11223344, 0, 32'h0,        1, 0, 8'h00, 1, 1, 32'h5);
        tbl[6]  = mk(0, 1, 32'h11223344, 0, 32'h0,        1, 1, 8'h44, 1, 0, 32'h5);
        tbl[7]  = mk(0, 1, 32'h11223344, 0, 32'h0,        1, 1, 8'h33, 1, 0, 32'h5);
        tbl[8]  = mk(0, 1, 32'h11223344, 0, 32'h0,        1, 1, 8'h22, 1, 0, 32'h5);
        tbl[9]  = mk(0, 1, 32'h11223344, 0, 32'h0,        1, 1, 8'h11, 1, 0, 32'h5);
        tbl[10] = mk(0, 1, 32'h11223344, 0, 32'h0,        1, 0, 8'h00, 0, 0, 32'h5);
        tbl[11] = mk(0, 1, 32'h11223344, 1, 32'hDEADBEEF, 1, 0, 8'h00, 0, 0, 32'hDEADBEEF);
        tbl[12] = mk(0, 1, 32'h11223344, 0, 32'h0,        1, 0, 8'h00, 0, 0, 32'hDEADBEEF);
        tbl[13] = mk(1, 1, 32'h11223344, 1, 32'h12345678, 1, 0, 8'h00, 1, 0, 32'h5);
        tbl[14] = mk(0, 0, 32'h11223344, 0, 32'h0,        1, 0, 8'h00, 1, 0, 32'h5);
        tbl[15] = mk(0, 1, 32'h0,        0, 32'h0,        1, 0, 8'h00, 1, 0, 32'h5);
        tbl[16] = mk(0, 1, 32'hA1B2C3D4, 0, 32'h0,        1, 0, 8'h00, 1, 1, 32'h5);
        tbl[17] = mk(0, 0, 32'hA1B2C3D4, 0, 32'h0,        0, 1, 8'hD4, 1, 0, 32'h5);
        tbl[18] = mk(0, 0, 32'hA1B2C3D4, 0, 32'h0,        1, 1, 8'hC3, 1, 0, 32'h5);
        tbl[19] = mk(0, 0, 32'hA1B2C3D4, 0, 32'h0,        0, 1, 8'hC3, 1, 0, 32'h5);
        tbl[20] = mk(0, 0, 32'hA1B2C3D4, 0, 32'h0,        0, 1, 8'hC3, 1, 0, 32'h5);
        tbl[21] = mk(0, 0, 32'hA1B2C3D4, 0, 32'h0,        0, 1, 8'hC3, 1, 0, 32'h5);
        tbl[22] = mk(0, 0, 32'hA1B2C3D4, 0, 32'h0,        1, 1, 8'hB2, 1, 0, 32'h5);
        tbl[23] = mk(0, 0, 32'hA1B2C3D4, 0, 32'h0,        1, 1, 8'hA1, 1, 0, 32'h5);
        tbl[24] = mk(0, 0, 32'hA1B2C3D4, 0, 32'h0,        1, 0, 8'h00, 0, 0, 32'h5);

        for (int i = 0; i < 25; i++) begin
            rst = tbl[i].rst; cap_en = tbl[i].cap; memoutput = tbl[i].mo;
            host_in_valid = tbl[i].hv; host_in_data = tbl[i].hd; byte_ready = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("row%0d byte_valid", i), 32'(byte_valid), 32'(tbl[i].e_bv));
            if (tbl[i].chk_bd)
                chk($sformatf("row%0d byte_data", i), 32'(byte_data), 32'(tbl[i].e_bd));
            chk($sformatf("row%0d fifo_level", i), 32'(fifo_level), 32'(tbl[i].e_lvl));
            chk($sformatf("row%0d meminput", i), meminput, tbl[i].e_min);
            chk($sformatf("row%0d overflow", i), 32'(overflow), 32'd0);
            chk($sformatf("row%0d drop_count", i), 32'(drop_count), 32'd0);
        end
        host_in_valid = 1'b0;

        // Overflow: ten distinct words with the sink stalled; word 10 has nowhere to go.
        byte_ready = 1'b0;
        cap_en     = 1'b1;
        for (int v = 1; v <= 10; v++) begin
            memoutput = 32'(v);
            @(negedge clk);
        end
        cap_en = 1'b0;
        chk("ovf fifo_level", 32'(fifo_level), 32'd8);
        chk("ovf drop_count", 32'(drop_count), 32'd1);
        chk("ovf overflow", 32'(overflow), 32'd1);
        chk("ovf head byte", 32'(byte_data), 32'h01);

        byte_ready = 1'b1;
        n_got = 0;
        cyc   = 0;
        while (n_got < 36 && cyc < 200) begin
            if (byte_valid) begin
                got[n_got] = byte_data;
                n_got++;
            end
            @(negedge clk);
            cyc++;
        end
        chk("ovf byte count", 32'(n_got), 32'd36);
        for (int w = 0; w < 9; w++) begin
            word = {got[4*w+3], got[4*w+2], got[4*w+1], got[4*w]};
            chk($sformatf("ovf word%0d", w + 1), word, 32'(w + 1));
        end
        chk("ovf tail byte_valid", 32'(byte_valid), 32'd0);
        chk("ovf tail fifo_level", 32'(fifo_level), 32'd0);
        chk("ovf sticky", 32'(overflow), 32'd1);
        chk("ovf drops held", 32'(drop_count), 32'd1);

        // Reset mid-word with three words still queued.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst2 overflow clr", 32'(overflow), 32'd0);
        chk("rst2 drops clr", 32'(drop_count), 32'd0);
        w4[0] = 32'h44332211; w4[1] = 32'h88776655;
        w4[2] = 32'hCCBBAA99; w4[3] = 32'h10FFEEDD;
        byte_ready = 1'b1;
        cap_en     = 1'b1;
        for (int k = 0; k < 4; k++) begin
            memoutput = w4[k];
            @(negedge clk);
        end
        cap_en = 1'b0;
        chk("mid fifo_level", 32'(fifo_level), 32'd3);
        chk("mid byte_data", 32'(byte_data), 32'h33);
        chk("mid byte_valid", 32'(byte_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid rst byte_valid", 32'(byte_valid), 32'd0);
        chk("mid rst fifo_level", 32'(fifo_level), 32'd0);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk($sformatf("mid stale c%0d", c), 32'(byte_valid), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mcpu_memio_port.md
Name: mcpu_memio_port

Overview:
Sits directly downstream of the MCPU core's memory-mapped debug I/O pins. It consumes the core's 32-bit memoutput, detects new values, buffers them in a small FIFO, and serializes each word into a byte stream with a valid/ready handshake for a host or console sink. It also drives the core's 32-bit meminput from a host-loadable register, replacing the constant tie-off used in simulation tops.

Parameters:
DEPTH, 8, FIFO depth in 32-bit words; must be a power of 2 and at least 2.
ON_CHANGE, 1, 1 = capture only when memoutput differs from the last captured value; 0 = capture every cycle that cap_en is high.
MEMIN_RESET, 32'd5, reset value of meminput.

Ports:
clkrst_core_clk  in  1  core clock; all logic on rising edge.
clkrst_core_rst  in  1  synchronous, active-high reset.
memoutput  in  32  from the core's memoutput.
cap_en  in  1  capture enable.
meminput  out  32  to the core's meminput.
host_in_valid  in  1  load strobe for meminput.
host_in_data  in  32  value to load into meminput.
byte_valid  out  1  stream byte valid.
byte_data  out  8  stream byte.
byte_ready  in  1  sink ready.
overflow  out  1  sticky flag: at least one word dropped.
drop_count  out  16  count of dropped words; saturates at 16'hFFFF.
fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (synchronous, sampled on the clock edge):
  - meminput = MEMIN_RESET; byte_valid = 0; byte_data = 0; overflow = 0; drop_count = 0; fifo_level = 0.
  - last-value register = 0; serializer returns to IDLE.
  - Any FIFO contents and any partially sent word are discarded.
  - Reset has priority over every other input.
- Capture event:
  - Occurs in a cycle where cap_en=1 AND (ON_CHANGE=0 OR memoutput != last).
  - On the event, last <= memoutput, whether or not the word is stored. A dropped value is never retried.
- FIFO push:
  - Word is written at the edge ending the capture cycle.
  - Push is accepted if fifo_level < DEPTH, or if a pop occurs at the same edge.
  - Otherwise the word is dropped: overflow <= 1 and drop_count increments (saturating).
- Serializer FSM, two states:
  - IDLE: if fifo_level > 0, pop the head into a 32-bit shift register, set byte index to 0, set byte_valid = 1, go to SEND.
  - SEND: byte_data = shreg[8*idx+7 : 8*idx], little-endian (byte 0 = bits [7:0]).
  - On byte_valid && byte_ready: if idx < 3, idx <= idx+1; else (idx = 3) pop the next word if the FIFO is non-empty and stay in SEND with idx = 0, otherwise go to IDLE with byte_valid = 0.
  - Back-to-back words stream with no bubble.
  - While byte_valid && !byte_ready, byte_data and byte_valid hold stable.
- Latency: a capture event in cycle N gives byte_valid = 1 with byte 0 in cycle N+2 (FIFO write at edge N, pop at edge N+1).
- Effective buffering is DEPTH+1 words (FIFO plus shift register).
- meminput: on host_in_valid=1, meminput <= host_in_data at the next edge. There is no backpressure, and this path is independent of the stream.
- fifo_level:
  - Push only: +1. Pop only: -1. Both at once: unchanged.
  - Never exceeds DEPTH and never underflows.
  - FIFO pointers wrap modulo DEPTH.

Test Plan:
1. Reset held 3 cycles, then released -> meminput = 0x00000005, byte_valid = 0, overflow = 0, drop_count = 0, fifo_level = 0. With ON_CHANGE=1 and memoutput = 0 held, no capture occurs.
2. memoutput steps 0 -> 0x11223344 in cycle N, cap_en = 1, byte_ready = 1 -> bytes 0x44, 0x33, 0x22, 0x11 in cycles N+2..N+5, then byte_valid = 0. Holding the same value causes no re-capture.
3. Backpressure: during byte 1 of 0xA1B2C3D4, byte_ready = 0 for 3 cycles -> byte_data stays 0xC3 with byte_valid = 1, then 0xB2 and 0xA1 follow. No bytes are lost.
4. Overflow: DEPTH = 8, ON_CHANGE = 0, byte_ready = 0, cap_en = 1 for 10 cycles with values 1..10 -> fifo_level = 8, drop_count = 1, overflow = 1. With ready then raised, the stream carries words 1..9 in order and 10 is absent.
5. host_in_valid = 1 with 0xDEADBEEF -> meminput = 0xDEADBEEF the next cycle. If the same edge also has clkrst_core_rst = 1 -> meminput = 0x00000005.
6. Reset asserted mid-word (after byte 1 has been accepted) with 3 words queued -> next cycle byte_valid = 0, fifo_level = 0. After release, no stale bytes are emitted.
